// File: rtl/spi_row_writer.sv
// -----------------------------------------------------------------------------
// spi_row_writer
//
// SPI master (mode 0) that commits one 16-bit word to a 13-bit row address of
// an external SPI non-volatile memory. Each request emits two frames:
//   1. WREN  : 8 bits, opcode 0x06
//   2. WRITE : 40 bits, {0x02, 3'b000, ROW_WRITE, DATA}
// with CS_N held high for CS_GAP cycles between them.
//
// Parameters
//   CLK_DIV  CLK cycles per SCLK half-period (>= 1)
//   CS_GAP   CLK cycles CS_N stays high between the two frames (>= 1)
//
// Ports
//   CLK        system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   START      one-cycle request, honoured only while idle
//   DATA       word to write (MSB first on the wire)
//   ROW_WRITE  row address (MSB first on the wire)
//   BUSY       high from the cycle after an accepted START until DONE
//   DONE       one-cycle pulse in the cycle CS_N rises after the write frame
//   SCLK       SPI clock, idle low, straight from a flop
//   MOSI       SPI data out
//   CS_N       SPI chip select, active low
// -----------------------------------------------------------------------------
module spi_row_writer #(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic [15:0] DATA,
   input  logic [12:0] ROW_WRITE,
   output logic        BUSY,
   output logic        DONE,
   output logic        SCLK,
   output logic        MOSI,
   output logic        CS_N
);

   localparam int HW = $clog2(CLK_DIV) + 1;
   localparam int GW = $clog2(CS_GAP) + 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
   localparam logic [7:0]    OP_WREN   = 8'h06;
   localparam logic [7:0]    OP_WRITE  = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WREN,
      S_GAP,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t        state_q,    state_d;
   logic [HW-1:0] half_q,     half_d;      // cycles spent in current SCLK phase
   logic [GW-1:0] gap_q,      gap_d;       // cycles spent with CS_N high in GAP
   logic [5:0]    bit_q,      bit_d;       // bits remaining after the current one
   logic          hold_q,     hold_d;      // trailing CS_N-low hold after last bit
   logic [7:0]    wren_sr_q,  wren_sr_d;
   logic [39:0]   write_sr_q, write_sr_d;
   logic          sclk_q,     sclk_d;
   logic          cs_n_q,     cs_n_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;

   // NOTE: every signal gets its hold value before the case statement, so no
   // path through the logic leaves a signal unassigned and no latch appears.
   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      gap_d      = gap_q;
      bit_d      = bit_q;
      hold_d     = hold_q;
      wren_sr_d  = wren_sr_q;
      write_sr_d = write_sr_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d    = S_WREN;
               wren_sr_d  = OP_WREN;
               write_sr_d = {OP_WRITE, 3'b000, ROW_WRITE, DATA};
               bit_d      = 6'd7;
               half_d     = '0;
               hold_d     = 1'b0;
               sclk_d     = 1'b0;
               cs_n_d     = 1'b0;
               busy_d     = 1'b1;
            end
         end

         S_WREN, S_WRITE: begin
            if (half_q != HALF_LAST) begin
               half_d = half_q + 1'b1;
            end else begin
               half_d = '0;
               if (hold_q) begin
                  // End of the hold phase: release chip select.
                  hold_d = 1'b0;
                  cs_n_d = 1'b1;
                  sclk_d = 1'b0;
                  if (state_q == S_WREN) begin
                     state_d = S_GAP;
                     gap_d   = '0;
                  end else begin
                     state_d = S_FINISH;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Falling SCLK: advance to the next bit, or enter the hold
                  // phase with the last bit left on MOSI.
                  sclk_d = 1'b0;
                  if (bit_q == 6'd0) begin
                     hold_d = 1'b1;
                  end else begin
                     bit_d = bit_q - 1'b1;
                     if (state_q == S_WREN) wren_sr_d  = {wren_sr_q[6:0], 1'b0};
                     else                   write_sr_d = {write_sr_q[38:0], 1'b0};
                  end
               end
            end
         end

         S_GAP: begin
            if (gap_q != GAP_LAST) begin
               gap_d = gap_q + 1'b1;
            end else begin
               state_d = S_WRITE;
               bit_d   = 6'd39;
               half_d  = '0;
               hold_d  = 1'b0;
               cs_n_d  = 1'b0;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of its inputs, independent of statement order.
   // NOTE: the shift registers are cleared on reset as well, so no stale word
   // from an interrupted request can ever reach the bus.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         half_q     <= '0;
         gap_q      <= '0;
         bit_q      <= '0;
         hold_q     <= 1'b0;
         wren_sr_q  <= '0;
         write_sr_q <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         gap_q      <= gap_d;
         bit_q      <= bit_d;
         hold_q     <= hold_d;
         wren_sr_q  <= wren_sr_d;
         write_sr_q <= write_sr_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // MOSI is the MSB of the active shift register. The registers only shift
   // on the edge where SCLK falls, so MOSI is constant while SCLK is high;
   // outside the two frames it is forced low.
   always_comb begin
      MOSI = 1'b0;
      if (state_q == S_WREN)       MOSI = wren_sr_q[7];
      else if (state_q == S_WRITE) MOSI = write_sr_q[39];
   end

   assign SCLK = sclk_q;
   assign CS_N = cs_n_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_spi_row_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_row_writer
//
// Two DUT instances share one clock: index 0 uses CLK_DIV=2/CS_GAP=4, index 1
// uses CLK_DIV=1/CS_GAP=1. Each transaction is traced one sample per cycle
// (on the falling clock edge) and compared against the expected bus behaviour
// derived from the frame format and timing formulas.
// -----------------------------------------------------------------------------
module tb_spi_row_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_n;
   logic [1:0]  start;
   logic [15:0] data_v [2];
   logic [12:0] row_v  [2];
   wire  [1:0]  busy, done, sclk, mosi, cs_n;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // Per-cycle trace of the instance under test, index 0 = START cycle.
   logic cs_t   [0:511];
   logic sclk_t [0:511];
   logic mosi_t [0:511];
   logic busy_t [0:511];
   logic done_t [0:511];

   spi_row_writer #(.CLK_DIV(2), .CS_GAP(4)) dut0 (
      .CLK(clk), .RESET_N(rst_n[0]), .START(start[0]), .DATA(data_v[0]),
      .ROW_WRITE(row_v[0]), .BUSY(busy[0]), .DONE(done[0]), .SCLK(sclk[0]),
      .MOSI(mosi[0]), .CS_N(cs_n[0]));

   spi_row_writer #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
      .CLK(clk), .RESET_N(rst_n[1]), .START(start[1]), .DATA(data_v[1]),
      .ROW_WRITE(row_v[1]), .BUSY(busy[1]), .DONE(done[1]), .SCLK(sclk[1]),
      .MOSI(mosi[1]), .CS_N(cs_n[1]));

   function automatic int div_of(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic int gap_of(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   // Issues one request on instance u (caller is at a falling edge, which
   // becomes cycle 0), traces it until DONE, and verifies the whole exchange.
   // With glitch set, START is pulsed at cycles 10 and 120 and DATA changes.
   task automatic run_txn(input int u, input logic [15:0] d, input logic [12:0] r,
                          input bit glitch, input string tag);
      int          dv        = div_of(u);
      int          gv        = gap_of(u);
      int          lat       = 1 + 17 * dv + gv + 81 * dv;
      int          budget    = lat + 20;
      int          n         = 0;
      int          m;
      logic [39:0] exp_frame = {8'h02, 3'b000, r, d};
      string       got_s     = "";
      string       exp_s;
      int          rl        = 0;
      int          f         = -1;
      logic [63:0] b0        = '0;
      logic [63:0] b1        = '0;
      int          n0        = 0;
      int          n1        = 0;
      int          bad       = 0;
      int          hi        = 0;
      int          bad_bd    = 0;

      start[u]  = 1'b1;
      data_v[u] = d;
      row_v[u]  = r;
      cs_t[0] = cs_n[u]; sclk_t[0] = sclk[u]; mosi_t[0] = mosi[u];
      busy_t[0] = busy[u]; done_t[0] = done[u];
      @(negedge clk);
      start[u] = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         cs_t[k] = cs_n[u]; sclk_t[k] = sclk[u]; mosi_t[k] = mosi[u];
         busy_t[k] = busy[u]; done_t[k] = done[u];
         if (done[u] === 1'b1) begin
            n = k;
            break;
         end
         start[u] = glitch && (k == 10 || k == 120);
         if (glitch && k == 10) data_v[u] = 16'hFFFF;
         @(negedge clk);
      end
      start[u] = 1'b0;
      m = (n == 0) ? budget : n;

      chk_cnt++;
      if (n !== lat) $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
      else pass_cnt++;

      // Chip-select run lengths over cycles 1..m.
      for (int k = 1; k <= m; k++) begin
         rl++;
         if (k == m || cs_t[k+1] !== cs_t[k]) begin
            got_s = {got_s, $sformatf("%0d:%0d ", cs_t[k], rl)};
            rl = 0;
         end
      end
      exp_s = $sformatf("0:%0d 1:%0d 0:%0d 1:1 ", 17 * dv, gv, 81 * dv);
      chk_cnt++;
      if (got_s != exp_s) $display("FAIL %s cs_runs: got %s expected %s", tag, got_s, exp_s);
      else pass_cnt++;

      // Bits captured on SCLK rising edges, grouped by chip-select frame.
      for (int k = 1; k <= m; k++) begin
         if (cs_t[k] === 1'b0 && cs_t[k-1] === 1'b1) f++;
         if (sclk_t[k] === 1'b1 && sclk_t[k-1] === 1'b0) begin
            if (f == 0) begin b0 = {b0[62:0], mosi_t[k]}; n0++; end
            else if (f == 1) begin b1 = {b1[62:0], mosi_t[k]}; n1++; end
         end
      end
      chk_cnt++;
      if (b0 !== 64'h06 || n0 != 8)
         $display("FAIL %s wren_frame: got %0d bits %h expected 8 bits 06", tag, n0, b0);
      else pass_cnt++;
      chk_cnt++;
      if (b1 !== {24'h0, exp_frame} || n1 != 40)
         $display("FAIL %s write_frame: got %0d bits %h expected 40 bits %h", tag, n1, b1, exp_frame);
      else pass_cnt++;

      // Bus discipline: SCLK high phases exactly CLK_DIV long, MOSI stable
      // while SCLK high, SCLK high only inside a frame, quiet bus when CS_N high.
      for (int k = 1; k <= m; k++) begin
         if (sclk_t[k] === 1'b1) begin
            hi++;
            if (cs_t[k] !== 1'b0) bad++;
            if (sclk_t[k-1] === 1'b1 && mosi_t[k] !== mosi_t[k-1]) bad++;
         end else begin
            if (hi != 0 && hi != dv) bad++;
            hi = 0;
         end
         if (cs_t[k] === 1'b1 && (sclk_t[k] !== 1'b0 || mosi_t[k] !== 1'b0)) bad++;
      end
      chk_cnt++;
      if (bad !== 0) $display("FAIL %s bus_discipline: got %0d violations expected 0", tag, bad);
      else pass_cnt++;

      // BUSY high and DONE low before the final cycle; DONE high, BUSY low in it.
      for (int k = 1; k < m; k++)
         if (busy_t[k] !== 1'b1 || done_t[k] !== 1'b0) bad_bd++;
      if (busy_t[m] !== 1'b0 || done_t[m] !== 1'b1) bad_bd++;
      chk_cnt++;
      if (bad_bd !== 0) $display("FAIL %s busy_done: got %0d bad cycles expected 0", tag, bad_bd);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 2'b00;
      start = 2'b00;
      data_v[0] = '0; data_v[1] = '0;
      row_v[0]  = '0; row_v[1]  = '0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({cs_n, sclk, mosi, busy, done} !== 10'b11_00_00_00_00)
         $display("FAIL reset_held: got %b expected %b", {cs_n, sclk, mosi, busy, done}, 10'b11_00_00_00_00);
      else pass_cnt++;
      rst_n = 2'b11;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({cs_n, sclk, mosi, busy, done} !== 10'b11_00_00_00_00)
         $display("FAIL reset_released: got %b expected %b", {cs_n, sclk, mosi, busy, done}, 10'b11_00_00_00_00);
      else pass_cnt++;
   endtask

   task automatic test_nominal();
      run_txn(0, 16'hA5C3, 13'h001D, 1'b0, "nominal");
      @(negedge clk);
      chk_cnt++;
      if ({done[0], busy[0], cs_n[0]} !== 3'b001)
         $display("FAIL nominal_after_done: got %b expected 001", {done[0], busy[0], cs_n[0]});
      else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int quiet = 0;
      run_txn(0, 16'hA5C3, 13'h001D, 1'b1, "glitch");
      // Still in the DONE cycle: this START must be dropped.
      start[0] = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({busy[0], cs_n[0]} !== 2'b01)
         $display("FAIL start_in_done: got busy,cs_n %b expected 01", {busy[0], cs_n[0]});
      else pass_cnt++;
      // START held into the cycle after DONE starts a new transaction.
      run_txn(0, 16'h3C5A, 13'h0ACE, 1'b0, "after_done");
      repeat (12) begin
         @(negedge clk);
         if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0) quiet++;
      end
      chk_cnt++;
      if (quiet !== 0) $display("FAIL no_queued_frame: got %0d active cycles expected 0", quiet);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      int act = 0;
      start[0]  = 1'b1;
      data_v[0] = 16'h1234;
      row_v[0]  = 13'h0ABC;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (120) @(negedge clk);   // cycle 121: inside write-frame bit 20
      chk_cnt++;
      if ({cs_n[0], busy[0]} !== 2'b01)
         $display("FAIL pre_reset_in_frame: got cs_n,busy %b expected 01", {cs_n[0], busy[0]});
      else pass_cnt++;
      rst_n[0] = 1'b0;
      #1;
      chk_cnt++;
      if ({cs_n[0], sclk[0], mosi[0], busy[0]} !== 4'b1000)
         $display("FAIL async_reset: got %b expected 1000", {cs_n[0], sclk[0], mosi[0], busy[0]});
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (sclk[0] !== 1'b0 || cs_n[0] !== 1'b1 || busy[0] !== 1'b0) act++;
      end
      chk_cnt++;
      if (act !== 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", act);
      else pass_cnt++;
      run_txn(0, 16'($urandom), 13'($urandom), 1'b0, "after_reset");
      @(negedge clk);
   endtask

   task automatic test_boundary();
      for (int u = 0; u < 2; u++) begin
         run_txn(u, 16'h0000, 13'h1FFF, 1'b0, $sformatf("bound_hi_row_u%0d", u));
         @(negedge clk);
         run_txn(u, 16'hFFFF, 13'h0000, 1'b0, $sformatf("bound_hi_data_u%0d", u));
         @(negedge clk);
      end
   endtask

   // Back-to-back random requests: each START lands in the cycle after DONE.
   task automatic test_back_to_back();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 4; i++) begin
            run_txn(u, 16'($urandom), 13'($urandom), 1'b0, $sformatf("rand_u%0d_%0d", u, i));
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_start_ignored();
      test_reset_mid_frame();
      test_boundary();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/spi_row_writer.md
Name: spi_row_writer

Overview:
- SPI master that consumes a 16-bit data word and a 13-bit row address from the constant/test-pattern source and commits the word to an external SPI non-volatile memory (FRAM/EEPROM style).
- Each request runs two frames: a write-enable (WREN, 0x06) frame, then a write frame (opcode 0x02, 16-bit address, 16-bit data).
- Sits between the DATA/ROW_WRITE source and the board SPI memory pins.

Parameters:
- CLK_DIV, 2, CLK cycles per SCLK half-period (≥1); one SCLK bit = 2*CLK_DIV CLK cycles.
- CS_GAP, 4, CLK cycles CS_N held high between the WREN frame and the write frame (≥1).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request; accepted only in IDLE.
- DATA  input  16  word to write, MSB first.
- ROW_WRITE  input  13  row address, MSB first.
- BUSY  output  1  high from the cycle after an accepted START until DONE.
- DONE  output  1  one-cycle pulse when the write frame completes.
- SCLK  output  1  SPI clock, mode 0 (idle low).
- MOSI  output  1  SPI data out.
- CS_N  output  1  SPI chip select, active low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, state=IDLE, all counters and shift registers cleared. No partial frame resumes after reset release.
- Acceptance:
  - START=1 in IDLE latches DATA and ROW_WRITE into a 40-bit write shift register: {0x02, 3'b000, ROW_WRITE, DATA}.
  - It also loads 0x06 into the 8-bit WREN shift register.
  - Input changes after acceptance have no effect on the frame.
- States and transitions:
  - IDLE -> WREN on accepted START.
  - WREN -> GAP after 8 bits.
  - GAP -> WRITE after CS_GAP cycles.
  - WRITE -> FINISH after 40 bits.
  - FINISH -> IDLE after one cycle.
- Frame timing (WREN and WRITE identical apart from bit count):
  - First cycle of the state: CS_N falls, MOSI presents the MSB, SCLK=0.
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI updates to the next bit on the cycle SCLK returns low, never while SCLK is high.
  - After the last high phase, SCLK=0 and CS_N stays low for CLK_DIV further cycles (hold), then CS_N rises.
  - WREN frame: CS_N low for 8*2*CLK_DIV + CLK_DIV cycles.
  - WRITE frame: CS_N low for 40*2*CLK_DIV + CLK_DIV cycles.
  - Exactly 8 and 40 SCLK rising edges respectively.
- GAP: CS_N=1, SCLK=0, MOSI=0 for exactly CS_GAP cycles.
- FINISH: the cycle in which CS_N rises at the end of the write frame.
  - DONE=1 for exactly one cycle.
  - BUSY falls in the same cycle.
  - MOSI=0, SCLK=0.
- START while BUSY=1 or during the FINISH/DONE cycle: ignored, no queuing. START in the cycle after DONE is accepted.
- SCLK never glitches: it is driven directly from a register. CS_N never toggles while SCLK=1.
- Internal counters:
  - Half-period counter: clog2(CLK_DIV)+1 bits, saturates and reloads; no wrap-around side effects.
  - Bit counter: 6 bits, counts down from 39 (WRITE) or 7 (WREN) to 0.
- Latency, START to DONE (CLK_DIV=2, CS_GAP=4): 1 + 34 + 4 + 162 = 201 cycles.

Test Plan:
1. Nominal frame: reset, DATA=0xA5C3, ROW_WRITE=13'h001D, START pulse. Sampling MOSI on SCLK rising edges must yield frame 1 = 0x06 (8 bits) and frame 2 = 0x02 0x00 0x1D 0xA5 0xC3 (40 bits). DONE is a single pulse at cycle 201 after START; BUSY is high cycles 1–200.
2. Timing check, CLK_DIV=2, CS_GAP=4: CS_N low 34 cycles, high exactly 4, low 162 cycles. SCLK high phases are exactly 2 cycles. MOSI stable throughout every SCLK-high phase.
3. START pulses at cycles 10 and 120 after an accepted START, plus DATA changed to 0xFFFF mid-frame: only one frame pair is emitted and its data is still 0xA5C3. START in the DONE cycle is ignored; START one cycle later starts a new transaction.
4. RESET_N low during write-frame bit 20: CS_N=1, SCLK=0, MOSI=0, BUSY=0 immediately (asynchronous). After release, no SCLK activity until a new START. A new START produces a full correct WREN + write sequence.
5. Boundary values: ROW_WRITE=13'h1FFF with DATA=0x0000 gives address bytes 0x1F 0xFF and data 0x00 0x00. ROW_WRITE=0 with DATA=0xFFFF gives 0x00 0x00 0xFF 0xFF. Repeat with CLK_DIV=1, CS_GAP=1: CS_N low 17 / high 1 / low 81 cycles.
